// File: rtl/mbus_rx_msg_sink_if.sv
// mbus_rx_msg_sink_if
// Bundles the MBus node receive handshake and the message reader port of
// mbus_rx_msg_sink.
//   slave  : the sink (receives RX_*, MSG_POP; drives RX_ACK, MSG_*, FAIL_CNT)
//   master : the node/reader side (the opposite directions)
interface mbus_rx_msg_sink_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) ();
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] RX_ADDR;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_REQ;
  logic              RX_PEND;
  logic              RX_FAIL;
  logic              RX_BROADCAST;
  logic              RX_ACK;
  logic              MSG_VALID;
  logic [ADDR_W-1:0] MSG_ADDR;
  logic              MSG_BCAST;
  logic [LEN_W-1:0]  MSG_LEN;
  logic              MSG_OVF;
  logic [DATA_W-1:0] MSG_DATA;
  logic              MSG_LAST;
  logic              MSG_POP;
  logic [7:0]        FAIL_CNT;

  modport slave (
    input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, RX_BROADCAST, MSG_POP,
    output RX_ACK, MSG_VALID, MSG_ADDR, MSG_BCAST, MSG_LEN, MSG_OVF,
           MSG_DATA, MSG_LAST, FAIL_CNT
  );

  modport master (
    output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, RX_BROADCAST, MSG_POP,
    input  RX_ACK, MSG_VALID, MSG_ADDR, MSG_BCAST, MSG_LEN, MSG_OVF,
           MSG_DATA, MSG_LAST, FAIL_CNT
  );
endinterface

// File: rtl/mbus_rx_msg_sink.sv
// mbus_rx_msg_sink
// Receives MBus words over a 4-phase RX_REQ/RX_ACK handshake, buffers up to
// DEPTH words of one message and presents them to a reader that pops them
// one at a time. Aborted messages (RX_FAIL) are discarded and counted.
// Ports:
//   CLK     sole clock, rising edge
//   RESETn  asynchronous active-low reset
//   bus     mbus_rx_msg_sink_if.slave (RX_* handshake in, MSG_* reader out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a word (synchronized RX_REQ high) or RX_FAIL
// ACK      | word taken, RX_ACK high until RX_REQ drops
// FAIL_ACK | abort acknowledged, RX_ACK high until RX_FAIL and RX_REQ drop
// READY    | complete message held for the reader, node is backpressured
module mbus_rx_msg_sink #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input logic CLK,
  input logic RESETn,
  mbus_rx_msg_sink_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_FAIL_ACK, S_READY} state_t;

  state_t state, state_nxt;

  logic req_s1, req_s2;
  logic fail_s1, fail_s2, fail_d;
  logic fail_rise;

  logic [DATA_W-1:0] msg_mem [DEPTH];
  logic [LEN_W-1:0]  wr_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic              ovf_q;
  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bcast_q;
  logic [7:0]        fail_cnt_q;

  logic store_word, drop_msg, pop_ok, room, last;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      req_s1  <= 1'b0;
      req_s2  <= 1'b0;
      fail_s1 <= 1'b0;
      fail_s2 <= 1'b0;
      fail_d  <= 1'b0;
    end else begin
      req_s1  <= bus.RX_REQ;
      req_s2  <= req_s1;
      fail_s1 <= bus.RX_FAIL;
      fail_s2 <= fail_s1;
      fail_d  <= fail_s2;
    end
  end

  // Counting rising edges means one held RX_FAIL is one event, in any state.
  assign fail_rise = fail_s2 & ~fail_d;
  assign room      = (wr_cnt < LEN_W'(DEPTH));
  assign last      = (state == S_READY) && ({1'b0, rd_ptr} == (wr_cnt - LEN_W'(1)));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // IDLE reacts to the RX_REQ level: every exit into IDLE happens with
  // RX_REQ low, except after READY or reset, where a held request must be
  // serviced as a fresh word.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fail_s2)     state_nxt = S_FAIL_ACK;
        else if (req_s2) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (fail_s2)      state_nxt = S_FAIL_ACK;
        else if (!req_s2) state_nxt = pend_q ? S_IDLE : S_READY;
      end
      S_FAIL_ACK: begin
        if (!fail_s2 && !req_s2) state_nxt = S_IDLE;
      end
      S_READY: begin
        if (bus.MSG_POP && last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    store_word    = (state == S_IDLE) && req_s2 && !fail_s2;
    drop_msg      = ((state == S_IDLE) || (state == S_ACK)) && fail_s2;
    pop_ok        = (state == S_READY) && bus.MSG_POP;
    bus.RX_ACK    = (state == S_ACK) || (state == S_FAIL_ACK);
    bus.MSG_VALID = (state == S_READY);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      bcast_q <= 1'b0;
    end else if (drop_msg) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else if (store_word) begin
      pend_q <= bus.RX_PEND;
      if (wr_cnt == '0) begin
        addr_q  <= bus.RX_ADDR;
        bcast_q <= bus.RX_BROADCAST;
      end
      if (room) wr_cnt <= wr_cnt + LEN_W'(1);
      else      ovf_q  <= 1'b1;
    end else if (pop_ok) begin
      if (last) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                            fail_cnt_q <= 8'h00;
    else if (fail_rise && fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'h01;
  end

  // Storage needs no reset; MSG_DATA is gated by MSG_VALID instead.
  always_ff @(posedge CLK) begin
    if (store_word && room) msg_mem[wr_cnt[PTR_W-1:0]] <= bus.RX_DATA;
  end

  assign bus.MSG_ADDR  = addr_q;
  assign bus.MSG_BCAST = bcast_q;
  assign bus.MSG_LEN   = wr_cnt;
  assign bus.MSG_OVF   = ovf_q;
  assign bus.MSG_DATA  = bus.MSG_VALID ? msg_mem[rd_ptr] : '0;
  assign bus.MSG_LAST  = last;
  assign bus.FAIL_CNT  = fail_cnt_q;
endmodule

// File: tb/tb_mbus_rx_msg_sink.sv
module tb_mbus_rx_msg_sink;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  mbus_rx_msg_sink_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

  mbus_rx_msg_sink #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int exp_fail = 0;
  logic [DW-1:0] msg_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat_fail();
    return (exp_fail > 255) ? 255 : exp_fail;
  endfunction

  // Bounded wait for RX_ACK to reach lvl; n = negedges waited.
  task automatic wait_ack(input logic lvl, input string tag, output int n);
    n = 0;
    while (bus.RX_ACK !== lvl && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (bus.RX_ACK !== lvl) begin
      errors++;
      $display("FAIL %s: RX_ACK timeout, actual %b required %b", tag, bus.RX_ACK, lvl);
    end
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic pend, input logic bc,
                           output int lat, output logic valid_at_fall);
    int n;
    @(negedge CLK);
    bus.RX_ADDR = addr; bus.RX_DATA = data; bus.RX_PEND = pend;
    bus.RX_BROADCAST = bc; bus.RX_REQ = 1'b1;
    wait_ack(1'b1, "ack_rise", lat);
    bus.RX_REQ = 1'b0;
    wait_ack(1'b0, "ack_fall", n);
    valid_at_fall = bus.MSG_VALID;
  endtask

  // Sends every word of msg_q; MSG_VALID must appear exactly as ACK falls
  // on the final word and never earlier.
  task automatic send_msg(input logic [AW-1:0] addr, input logic bc);
    int lat;
    logic v;
    for (int i = 0; i < msg_q.size(); i++) begin
      send_word(addr, msg_q[i], (i != msg_q.size() - 1), bc, lat, v);
      checks++;
      if (v !== (i == msg_q.size() - 1)) begin
        errors++;
        $display("FAIL valid_at_ack_fall word %0d: actual %b required %b", i, v, (i == msg_q.size() - 1));
      end
    end
  endtask

  // Reader: expected contents come from msg_q truncated to DEPTH.
  task automatic read_msg(input logic [AW-1:0] addr, input logic bc);
    int n = 0;
    int elen = (msg_q.size() > DEPTH) ? DEPTH : msg_q.size();
    logic eovf = (msg_q.size() > DEPTH);
    while (bus.MSG_VALID !== 1'b1 && n < 60) begin @(negedge CLK); n++; end
    checks++;
    if (bus.MSG_VALID !== 1'b1) begin
      errors++;
      $display("FAIL msg_valid wait: actual %b required 1", bus.MSG_VALID);
    end
    checks++;
    if (bus.MSG_LEN !== elen[$bits(bus.MSG_LEN)-1:0]) begin
      errors++; $display("FAIL msg_len: actual %0d required %0d", bus.MSG_LEN, elen);
    end
    checks++;
    if (bus.MSG_OVF !== eovf) begin
      errors++; $display("FAIL msg_ovf: actual %b required %b", bus.MSG_OVF, eovf);
    end
    checks++;
    if (bus.MSG_ADDR !== addr || bus.MSG_BCAST !== bc) begin
      errors++; $display("FAIL msg_addr/bcast: actual %h/%b required %h/%b", bus.MSG_ADDR, bus.MSG_BCAST, addr, bc);
    end
    for (int i = 0; i < elen; i++) begin
      checks++;
      if (bus.MSG_DATA !== msg_q[i]) begin
        errors++; $display("FAIL msg_data[%0d]: actual %h required %h", i, bus.MSG_DATA, msg_q[i]);
      end
      checks++;
      if (bus.MSG_LAST !== (i == elen - 1)) begin
        errors++; $display("FAIL msg_last[%0d]: actual %b required %b", i, bus.MSG_LAST, (i == elen - 1));
      end
      bus.MSG_POP = 1'b1;
      @(negedge CLK);
      bus.MSG_POP = 1'b0;
    end
    checks++;
    if (bus.MSG_VALID !== 1'b0) begin
      errors++; $display("FAIL valid_after_last_pop: actual %b required 0", bus.MSG_VALID);
    end
  endtask

  task automatic do_fail(input logic with_req);
    int n;
    @(negedge CLK);
    bus.RX_FAIL = 1'b1;
    bus.RX_REQ  = with_req;
    wait_ack(1'b1, "fail_ack_rise", n);
    bus.RX_FAIL = 1'b0;
    bus.RX_REQ  = 1'b0;
    wait_ack(1'b0, "fail_ack_fall", n);
    exp_fail++;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (bus.RX_ACK !== 1'b0 || bus.MSG_VALID !== 1'b0 || bus.MSG_OVF !== 1'b0 ||
        bus.MSG_LEN !== '0 || bus.MSG_LAST !== 1'b0 || bus.FAIL_CNT !== 8'h00 ||
        bus.MSG_DATA !== '0 || bus.MSG_ADDR !== '0 || bus.MSG_BCAST !== 1'b0) begin
      errors++;
      $display("FAIL %s: ack=%b valid=%b ovf=%b len=%0d last=%b fcnt=%0d data=%h addr=%h bc=%b required all 0",
               tag, bus.RX_ACK, bus.MSG_VALID, bus.MSG_OVF, bus.MSG_LEN, bus.MSG_LAST,
               bus.FAIL_CNT, bus.MSG_DATA, bus.MSG_ADDR, bus.MSG_BCAST);
    end
  endtask

  task automatic test_reset();
    bus.RX_ADDR = '0; bus.RX_DATA = '0; bus.RX_REQ = 0; bus.RX_PEND = 0;
    bus.RX_FAIL = 0; bus.RX_BROADCAST = 0; bus.MSG_POP = 0;
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero("reset_state");
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    check_zero("after_release");
  endtask

  task automatic test_single();
    int lat;
    logic v;
    msg_q = {32'hDEADBEEF};
    send_word(32'hBBBB1, 32'hDEADBEEF, 1'b0, 1'b0, lat, v);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL ack_latency: actual %0d required 3", lat); end
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL single_valid_at_fall: actual %b required 1", v); end
    read_msg(32'hBBBB1, 1'b0);
  endtask

  task automatic test_three();
    msg_q = {32'h1, 32'h2, 32'h3};
    send_msg(32'h0000_0A5A, 1'b1);
    read_msg(32'h0000_0A5A, 1'b1);
  endtask

  task automatic test_overflow();
    logic [AW-1:0] a = $urandom;
    msg_q = {};
    for (int i = 0; i < DEPTH + 2; i++) msg_q.push_back($urandom);
    send_msg(a, 1'b0);
    read_msg(a, 1'b0);
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      logic [AW-1:0] a = $urandom;
      logic bc = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, DEPTH + 3);
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back($urandom);
      send_msg(a, bc);
      read_msg(a, bc);
    end
  endtask

  task automatic test_fail();
    int lat;
    logic v;
    logic [AW-1:0] a = $urandom;
    send_word(32'hF00D, $urandom, 1'b1, 1'b1, lat, v);
    send_word(32'hF00D, $urandom, 1'b1, 1'b1, lat, v);
    do_fail(1'b0);
    checks++;
    if (bus.FAIL_CNT !== 8'(sat_fail())) begin
      errors++; $display("FAIL fail_cnt_after_abort: actual %0d required %0d", bus.FAIL_CNT, sat_fail());
    end
    checks++;
    if (bus.MSG_VALID !== 1'b0) begin
      errors++; $display("FAIL valid_after_abort: actual %b required 0", bus.MSG_VALID);
    end
    // Fail and request together: the word must not be kept.
    bus.RX_DATA = 32'hBAD0BAD0; bus.RX_PEND = 1'b0;
    do_fail(1'b1);
    repeat (4) @(negedge CLK);
    checks++;
    if (bus.MSG_VALID !== 1'b0 || bus.FAIL_CNT !== 8'(sat_fail())) begin
      errors++; $display("FAIL fail_priority: valid %b fcnt %0d required 0 %0d", bus.MSG_VALID, bus.FAIL_CNT, sat_fail());
    end
    msg_q = {};
    for (int i = 0; i < 2; i++) msg_q.push_back($urandom);
    send_msg(a, 1'b0);
    read_msg(a, 1'b0);
  endtask

  task automatic test_pop_idle();
    int lat;
    logic v;
    logic [AW-1:0] a = $urandom;
    msg_q = {$urandom, $urandom};
    send_word(a, msg_q[0], 1'b1, 1'b0, lat, v);
    @(negedge CLK);
    bus.MSG_POP = 1'b1;
    repeat (2) @(negedge CLK);
    bus.MSG_POP = 1'b0;
    send_word(a, msg_q[1], 1'b0, 1'b0, lat, v);
    read_msg(a, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [DW-1:0] qb[$];
    logic [AW-1:0] aa = $urandom;
    logic [AW-1:0] ab = $urandom;
    msg_q = {$urandom, $urandom, $urandom};
    send_msg(aa, 1'b0);
    // RX_FAIL while READY: counted, message kept, no ack.
    @(negedge CLK);
    bus.RX_FAIL = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if (bus.RX_ACK !== 1'b0 || bus.MSG_VALID !== 1'b1) begin
      errors++; $display("FAIL ready_fail_ignored: ack %b valid %b required 0 1", bus.RX_ACK, bus.MSG_VALID);
    end
    bus.RX_FAIL = 1'b0;
    exp_fail++;
    repeat (4) @(negedge CLK);
    checks++;
    if (bus.FAIL_CNT !== 8'(sat_fail())) begin
      errors++; $display("FAIL ready_fail_count: actual %0d required %0d", bus.FAIL_CNT, sat_fail());
    end
    qb = {};
    for (int i = 0; i < 4; i++) qb.push_back($urandom);
    bus.RX_ADDR = ab; bus.RX_DATA = qb[0]; bus.RX_PEND = 1'b1;
    bus.RX_BROADCAST = 1'b1; bus.RX_REQ = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if (bus.RX_ACK !== 1'b0) begin
      errors++; $display("FAIL backpressure: RX_ACK actual %b required 0", bus.RX_ACK);
    end
    read_msg(aa, 1'b0);
    wait_ack(1'b1, "held_req_ack", n);
    bus.RX_REQ = 1'b0;
    wait_ack(1'b0, "held_req_ack_fall", n);
    for (int i = 1; i < qb.size(); i++) begin
      logic v;
      int lat;
      send_word(ab, qb[i], (i != qb.size() - 1), 1'b1, lat, v);
    end
    msg_q = qb;
    read_msg(ab, 1'b1);
  endtask

  task automatic test_fail_saturate();
    while (exp_fail < 256) do_fail(1'b0);
    checks++;
    if (bus.FAIL_CNT !== 8'hFF) begin
      errors++; $display("FAIL fail_cnt_saturate: actual %0d required 255", bus.FAIL_CNT);
    end
    do_fail(1'b0);
    checks++;
    if (bus.FAIL_CNT !== 8'hFF) begin
      errors++; $display("FAIL fail_cnt_hold: actual %0d required 255", bus.FAIL_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [AW-1:0] a = $urandom;
    msg_q = {$urandom};
    @(negedge CLK);
    bus.RX_ADDR = a; bus.RX_DATA = msg_q[0]; bus.RX_PEND = 1'b0;
    bus.RX_BROADCAST = 1'b1; bus.RX_REQ = 1'b1;
    wait_ack(1'b1, "mid_ack_rise", n);
    #2 RESETn = 1'b0;
    #1 check_zero("reset_mid_handshake");
    exp_fail = 0;
    @(negedge CLK);
    RESETn = 1'b1;
    // Request still high after release: must be taken as a new word.
    wait_ack(1'b1, "post_reset_ack", n);
    bus.RX_REQ = 1'b0;
    wait_ack(1'b0, "post_reset_ack_fall", n);
    read_msg(a, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_overflow();
    test_random();
    test_fail();
    test_pop_idle();
    test_back_to_back();
    test_fail_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
